// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: drains UART RX bytes and parses SYNC/ADDR/DATA frames into register writes.
// Define UART_CMD_CSUM_EN to add a trailing XOR checksum byte to every frame.
module uart_cmd_sequencer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         DATA_BYTES     = 2,
    parameter int         TIMEOUT_CYCLES = 40000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    byte_rdy,
    input  logic [7:0]              rx_data,
    output logic                    uld_rx_data,
    output logic                    wr_en,
    output logic [7:0]              wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    busy,
    output logic                    err_timeout,
    output logic                    err_csum
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DATA_BYTES - 1);

    typedef enum logic [1:0] {F_IDLE, F_UNLD, F_CAPT} fetch_e;
    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        DATA,
`ifdef UART_CMD_CSUM_EN
        CSUM,
`endif
        WRITE
    } frame_e;

    fetch_e          fetch_q, fetch_d;
    frame_e          frame_q, frame_d;
    logic            byte_stb;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW-1:0]   data_shift;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
`ifdef UART_CMD_CSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_q   <= F_IDLE;
            frame_q   <= HUNT;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            timer_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef UART_CMD_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            fetch_q   <= fetch_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            timer_q   <= timer_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef UART_CMD_CSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // byte_rdy is still clearing during UNLD/CAPT, so it is only looked at from IDLE.
    always_comb begin
        fetch_d     = fetch_q;
        uld_rx_data = 1'b0;
        byte_stb    = 1'b0;
        case (fetch_q)
            F_IDLE: if (byte_rdy) fetch_d = F_UNLD;
            F_UNLD: begin
                uld_rx_data = 1'b1;
                fetch_d     = F_CAPT;
            end
            F_CAPT: begin
                byte_stb = 1'b1;
                fetch_d  = F_IDLE;
            end
            default: fetch_d = F_IDLE;
        endcase
    end

    assign data_shift = DW'({data_q, rx_data});

    // Output registers load on the edge into WRITE so wr_addr/wr_data are valid alongside wr_en.
    always_comb begin
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en       = 1'b0;
        err_timeout = 1'b0;
`ifdef UART_CMD_CSUM_EN
        csum_d      = csum_q;
        err_csum    = 1'b0;
`endif
        if (frame_q == HUNT || byte_stb) begin
            timer_d = '0;
        end else if (timer_q != T_LAST) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end

        case (frame_q)
            HUNT: if (byte_stb && rx_data == SYNC_BYTE) frame_d = ADDR;
            ADDR: if (byte_stb) begin
                addr_d  = rx_data;
                cnt_d   = '0;
                frame_d = DATA;
`ifdef UART_CMD_CSUM_EN
                csum_d  = rx_data;
`endif
            end
            DATA: if (byte_stb) begin
                data_d = data_shift;
                cnt_d  = cnt_q + CW'(1);
`ifdef UART_CMD_CSUM_EN
                csum_d = csum_q ^ rx_data;
`endif
                if (cnt_q == C_LAST) begin
`ifdef UART_CMD_CSUM_EN
                    frame_d   = CSUM;
`else
                    frame_d   = WRITE;
                    wr_addr_d = addr_q;
                    wr_data_d = data_shift;
`endif
                end
            end
`ifdef UART_CMD_CSUM_EN
            CSUM: if (byte_stb) begin
                if (rx_data == csum_q) begin
                    frame_d   = WRITE;
                    wr_addr_d = addr_q;
                    wr_data_d = data_q;
                end else begin
                    err_csum = 1'b1;
                    frame_d  = HUNT;
                end
            end
`endif
            WRITE: begin
                wr_en   = 1'b1;
                frame_d = HUNT;
            end
            default: frame_d = HUNT;
        endcase

        // A byte arriving on the expiry cycle keeps the frame alive.
        if (frame_q != HUNT && frame_q != WRITE && !byte_stb && timer_q == T_LAST) begin
            err_timeout = 1'b1;
            frame_d     = HUNT;
        end
    end

`ifndef UART_CMD_CSUM_EN
    assign err_csum = 1'b0;
`endif

    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (frame_q != HUNT);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: directed frames plus randomized byte streams
// checked against a queue-based frame parser model.
module tb_uart_cmd_sequencer;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int DB   = 2;
    localparam int TO   = 50;
    localparam int DW   = 8 * DB;
`ifdef UART_CMD_CSUM_EN
    localparam int FLEN = 3 + DB;
`else
    localparam int FLEN = 2 + DB;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          byte_rdy = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          uld_rx_data, wr_en, busy, err_timeout, err_csum;
    logic [7:0]    wr_addr;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    uart_cmd_sequencer #(
        .SYNC_BYTE(SYNC), .DATA_BYTES(DB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .byte_rdy(byte_rdy), .rx_data(rx_data),
        .uld_rx_data(uld_rx_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .err_timeout(err_timeout), .err_csum(err_csum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: logs every output pulse on the falling edge, away from the active edge.
    int uldCount = 0, wrCount = 0, toCount = 0, csCount = 0;
    int lastUldCyc = 0, lastWrCyc = 0, lastToCyc = 0;
    logic [7:0]    wrAddrLog [256];
    logic [DW-1:0] wrDataLog [256];
    always @(negedge clk) begin
        if (reset_n) begin
            if (uld_rx_data) begin
                uldCount   <= uldCount + 1;
                lastUldCyc <= cyc;
            end
            if (wr_en) begin
                if (wrCount < 256) begin
                    wrAddrLog[wrCount] <= wr_addr;
                    wrDataLog[wrCount] <= wr_data;
                end
                wrCount   <= wrCount + 1;
                lastWrCyc <= cyc;
            end
            if (err_timeout) begin
                toCount   <= toCount + 1;
                lastToCyc <= cyc;
            end
            if (err_csum) csCount <= csCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // UART RX stand-in: waits for the unload request, then presents the byte and drops byte_rdy.
    task automatic fetchPending(input logic [7:0] b);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uld_rx_data && n < 40);
        if (!uld_rx_data) begin
            checks++;
            errors++;
            $display("[TB] FAIL fetch_wait observed=no_unload expected=unload_within_40");
            byte_rdy = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_data  = b;
            byte_rdy = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap + 1) @(posedge clk);
        #1;
        byte_rdy = 1'b1;
        fetchPending(b);
    endtask

    function automatic logic [7:0] frameCsum(input logic [7:0] a, input logic [DW-1:0] d);
        logic [7:0] x = a;
        for (int i = 0; i < DB; i++) x ^= d[8*i +: 8];
        return x;
    endfunction

    task automatic sendFrame(input logic [7:0] a, input logic [DW-1:0] d, input int gap);
        applyStimulus(SYNC, gap);
        applyStimulus(a, gap);
        for (int i = DB - 1; i >= 0; i--) applyStimulus(d[8*i +: 8], gap);
`ifdef UART_CMD_CSUM_EN
        applyStimulus(frameCsum(a, d), gap);
`endif
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference model: a byte buffer that starts on SYNC and evaluates once a full frame is held.
    logic [7:0]    mbuf [$];
    logic [7:0]    expAddr [$];
    logic [DW-1:0] expData [$];
    int expTo = 0, expCs = 0, sentBytes = 0;

    task automatic modelByte(input logic [7:0] b);
        logic [DW-1:0] d;
        if (mbuf.size() == 0 && b != SYNC) return;
        mbuf.push_back(b);
        if (mbuf.size() == FLEN) begin
            d = '0;
            for (int i = 0; i < DB; i++) d = (d << 8) | DW'(mbuf[2 + i]);
`ifdef UART_CMD_CSUM_EN
            if (mbuf[FLEN - 1] == frameCsum(mbuf[1], d)) begin
                expAddr.push_back(mbuf[1]);
                expData.push_back(d);
            end else begin
                expCs++;
            end
`else
            expAddr.push_back(mbuf[1]);
            expData.push_back(d);
`endif
            mbuf.delete();
        end
    endtask

    task automatic sendM(input logic [7:0] b, input int gap);
        applyStimulus(b, gap);
        modelByte(b);
        sentBytes++;
    endtask

    task automatic longGapM();
        repeat (TO + 10) @(posedge clk);
        #1;
        if (mbuf.size() != 0) begin
            expTo++;
            mbuf.delete();
        end
    endtask

    initial begin
        int u0, w0, t0, c0, kind, n;
        logic [7:0] fb [FLEN];
        logic [7:0] a, g;
        logic [DW-1:0] d;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_uld", uld_rx_data, 0);
        checkOutput("reset_wr_en", wr_en, 0);
        checkOutput("reset_wr_addr", wr_addr, 0);
        checkOutput("reset_wr_data", wr_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err_to", err_timeout, 0);
        checkOutput("reset_err_cs", err_csum, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single good frame and write latency
        $display("[TB] good frame");
        w0 = wrCount;
        sendFrame(8'h12, 16'hBEEF, 0);
        settle();
        checkOutput("t1_writes", wrCount - w0, 1);
        checkOutput("t1_addr", wrAddrLog[w0], 8'h12);
        checkOutput("t1_data", wrDataLog[w0], 16'hBEEF);
        checkOutput("t1_latency", lastWrCyc - lastUldCyc, 2);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_hold_addr", wr_addr, 8'h12);

        // Leading garbage is unloaded and discarded
        $display("[TB] leading garbage");
        u0 = uldCount; w0 = wrCount;
        applyStimulus(8'h00, 2);
        applyStimulus(8'hFF, 1);
        sendFrame(8'h03, 16'h0001, 0);
        settle();
        checkOutput("t2_unloads", uldCount - u0, 2 + FLEN);
        checkOutput("t2_writes", wrCount - w0, 1);
        checkOutput("t2_addr", wrAddrLog[w0], 8'h03);
        checkOutput("t2_data", wrDataLog[w0], 16'h0001);

        // Partial frame then silence
        $display("[TB] inter-byte timeout");
        w0 = wrCount; t0 = toCount;
        applyStimulus(SYNC, 0);
        applyStimulus(8'h20, 0);
        applyStimulus(8'h11, 0);
        repeat (TO + 10) @(posedge clk);
        #1;
        checkOutput("t3_timeouts", toCount - t0, 1);
        checkOutput("t3_to_cycle", lastToCyc - lastUldCyc, TO + 1);
        checkOutput("t3_no_write", wrCount - w0, 0);
        checkOutput("t3_addr_kept", wr_addr, 8'h03);
        checkOutput("t3_data_kept", wr_data, 16'h0001);
        checkOutput("t3_busy", busy, 0);
        sendFrame(8'h21, 16'h2233, 1);
        settle();
        checkOutput("t3_writes", wrCount - w0, 1);
        checkOutput("t3_addr", wr_addr, 8'h21);
        checkOutput("t3_data", wr_data, 16'h2233);

`ifdef UART_CMD_CSUM_EN
        $display("[TB] checksum");
        w0 = wrCount; c0 = csCount;
        applyStimulus(SYNC, 0); applyStimulus(8'h12, 0); applyStimulus(8'hBE, 0);
        applyStimulus(8'hEF, 0); applyStimulus(8'h43, 0);
        settle();
        checkOutput("t4_good_write", wrCount - w0, 1);
        checkOutput("t4_good_data", wr_data, 16'hBEEF);
        applyStimulus(SYNC, 0); applyStimulus(8'h34, 0); applyStimulus(8'hBE, 0);
        applyStimulus(8'hEF, 0); applyStimulus(8'h44, 0);
        settle();
        checkOutput("t4_bad_err", csCount - c0, 1);
        checkOutput("t4_bad_nowrite", wrCount - w0, 1);
        checkOutput("t4_addr_kept", wr_addr, 8'h12);
`endif

        // Back-to-back frames at full byte rate
        $display("[TB] back-to-back");
        u0 = uldCount; w0 = wrCount;
        sendFrame(8'h40, 16'h1234, 0);
        sendFrame(8'h41, 16'hA5A5, 0);
        settle();
        checkOutput("t5_unloads", uldCount - u0, 2 * FLEN);
        checkOutput("t5_writes", wrCount - w0, 2);
        checkOutput("t5_addr0", wrAddrLog[w0], 8'h40);
        checkOutput("t5_data0", wrDataLog[w0], 16'h1234);
        checkOutput("t5_addr1", wrAddrLog[w0 + 1], 8'h41);
        checkOutput("t5_data1", wrDataLog[w0 + 1], 16'hA5A5);

        // Reset mid-frame, with byte_rdy already high at release
        $display("[TB] reset mid-frame");
        w0 = wrCount;
        applyStimulus(SYNC, 0);
        applyStimulus(8'h12, 0);
        applyStimulus(8'hBE, 0);
        @(posedge clk);
        #1;
        checkOutput("t6_busy_mid", busy, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_addr", wr_addr, 0);
        checkOutput("t6_rst_data", wr_data, 0);
        checkOutput("t6_rst_uld", uld_rx_data, 0);
        byte_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        fetchPending(SYNC);
        applyStimulus(8'h12, 0);
        applyStimulus(8'hBE, 0);
        applyStimulus(8'hEF, 0);
`ifdef UART_CMD_CSUM_EN
        applyStimulus(8'h43, 0);
`endif
        settle();
        checkOutput("t6_writes", wrCount - w0, 1);
        checkOutput("t6_addr", wr_addr, 8'h12);
        checkOutput("t6_data", wr_data, 16'hBEEF);

        // Randomized byte streams against the reference model
        $display("[TB] random streams");
        u0 = uldCount; w0 = wrCount; t0 = toCount; c0 = csCount;
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            a = 8'($urandom);
            d = DW'($urandom);
            fb[0] = SYNC;
            fb[1] = a;
            for (int i = 0; i < DB; i++) fb[2 + i] = d[8*(DB-1-i) +: 8];
`ifdef UART_CMD_CSUM_EN
            fb[FLEN - 1] = frameCsum(a, d) ^ ((kind == 3) ? 8'h01 : 8'h00);
`endif
            if (kind == 1) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) begin
                    g = 8'($urandom);
                    if (g == SYNC) g = 8'h00;
                    sendM(g, $urandom_range(0, 4));
                end
            end
            n = (kind == 2) ? $urandom_range(1, FLEN - 1) : FLEN;
            for (int i = 0; i < n; i++) sendM(fb[i], $urandom_range(0, 4));
            if (kind == 2) longGapM();
        end
        longGapM();
        checkOutput("rnd_unloads", uldCount - u0, sentBytes);
        checkOutput("rnd_writes", wrCount - w0, expAddr.size());
        checkOutput("rnd_timeouts", toCount - t0, expTo);
        checkOutput("rnd_csum_errs", csCount - c0, expCs);
        for (int i = 0; i < expAddr.size() && i < wrCount - w0 && w0 + i < 256; i++) begin
            checkOutput($sformatf("rnd_addr_%0d", i), wrAddrLog[w0 + i], expAddr[i]);
            checkOutput($sformatf("rnd_data_%0d", i), wrDataLog[w0 + i], expData[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
